npc_gen: RTL and testbench
==========================

NPC_GEN -- requirements
Module: npc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter EXC_PC, default 32'h0000_4180, legal upper fetch bound (inclusive, exception handler entry).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; low at a rising edge resets all state.
REQ-005 stall  in  1  D-stage hazard stall; PC and all state hold.
REQ-006 instr_D  in  32  instruction currently in D.
REQ-007 PC4_D  in  32  address of instr_D plus 4.
REQ-008 rs_D, rt_D  in  32 each  forwarded register operands of instr_D.
REQ-009 epc  in  32  exception return address.
REQ-010 NPC  in  32  selected next PC returned from the next-PC mux.
REQ-011 NPC_ctrl  out  3  mux select: 000 PC4, 001 BR, 010 JR, 011 J_JAL, 100 JI.
REQ-012 BR, JR, J_JAL, JI  out  32 each  candidate targets.
REQ-013 PC_F, PC4_F  out  32 each  fetch address and fetch address plus 4.
REQ-014 flush_FD  out  1  clear IF/ID register this edge.
REQ-015 bd_D  out  1  registered flag: instruction now in D is a delay slot.
REQ-016 adel_F  out  1  registered flag: PC_F misaligned or out of range.
REQ-017 redir_cnt  out  16  count of taken redirects.

Function
REQ-018 BR SHALL equal PC4_D + (sign-extended instr_D[15:0] << 2), mod 2^32.
REQ-019 J_JAL SHALL equal {PC4_D[31:28], instr_D[25:0], 2'b00}; JR SHALL equal rs_D; JI SHALL equal epc; PC4_F SHALL equal PC_F + 4, mod 2^32.
REQ-020 Decode: beq (op 04, rs==rt), bne (05, rs!=rt), blez (06, rs<=0 signed), bgtz (07, rs>0 signed), bltz (01/rt=0, rs<0), bgez (01/rt=1, rs>=0); taken -> 001.
REQ-021 j, jal (op 02/03) -> 011; jr, jalr (op 00, funct 08/09) -> 010; eret (32'h4200_0018) -> 100; all else, including untaken branches -> 000.
REQ-022 While stall=1, NPC_ctrl SHALL be 000 and flush_FD 0.
REQ-023 Each edge with reset high and stall=0: PC_F <= NPC.
REQ-024 Each edge with stall=0: bd_D <= 1 if instr_D is any branch or jump (taken or not, excluding eret), else 0.
REQ-025 flush_FD SHALL be 1 combinationally when instr_D is eret and stall=0 (eret has no delay slot).
REQ-026 Each edge with stall=0 and NPC_ctrl!=000: redir_cnt increments, saturating at 16'hFFFF.
REQ-027 adel_F SHALL be registered from the value loaded into PC_F: 1 if NPC[1:0]!=0 or NPC outside [RESET_PC, EXC_PC+32'h1C7C]; the PC still loads NPC.
REQ-028 Branch in D with delay-slot instruction stalled in F: no redirect until stall drops; redirect then occurs exactly once.

Reset
REQ-029 reset low at an edge: PC_F=RESET_PC, bd_D=0, adel_F=0, redir_cnt=0; reset dominates stall.
REQ-030 Reset mid-redirect discards the pending redirect; first post-reset fetch is RESET_PC.

Verification
REQ-031 reset low one edge -> PC_F=32'h3000, PC4_F=32'h3004, redir_cnt=0, bd_D=0.
REQ-032 instr_D=beq, rs_D=rt_D=5, PC4_D=32'h3008, imm=16'hFFFE -> BR=32'h3000, NPC_ctrl=001; next edge bd_D=1, redir_cnt=1.
REQ-033 Same beq with stall=1 for 3 cycles -> NPC_ctrl=000, PC_F constant; stall drops -> 001, redir_cnt increments once.
REQ-034 instr_D=jr, rs_D=32'h3002 -> NPC_ctrl=010; next edge PC_F=32'h3002, adel_F=1.
REQ-035 instr_D=eret, epc=32'h3100 -> NPC_ctrl=100, flush_FD=1; next edge PC_F=32'h3100, bd_D=0.
REQ-036 redir_cnt preloaded to 16'hFFFF via 65535 taken jumps, one more jal -> redir_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/npc_gen_if.sv
// Next-PC generator bus: D-stage instruction context in, fetch PC,
// redirect candidates and mux select out.
interface npc_gen_if;
   logic        stall;
   logic [31:0] instr_D;
   logic [31:0] PC4_D;
   logic [31:0] rs_D;
   logic [31:0] rt_D;
   logic [31:0] epc;
   logic [31:0] NPC;

   logic [2:0]  NPC_ctrl;
   logic [31:0] BR;
   logic [31:0] JR;
   logic [31:0] J_JAL;
   logic [31:0] JI;
   logic [31:0] PC_F;
   logic [31:0] PC4_F;
   logic        flush_FD;
   logic        bd_D;
   logic        adel_F;
   logic [15:0] redir_cnt;

   // Pipeline side: drives D-stage context and the selected NPC
   modport master (
      output stall, instr_D, PC4_D, rs_D, rt_D, epc, NPC,
      input  NPC_ctrl, BR, JR, J_JAL, JI, PC_F, PC4_F,
             flush_FD, bd_D, adel_F, redir_cnt
   );

   // Generator side
   modport slave (
      input  stall, instr_D, PC4_D, rs_D, rt_D, epc, NPC,
      output NPC_ctrl, BR, JR, J_JAL, JI, PC_F, PC4_F,
             flush_FD, bd_D, adel_F, redir_cnt
   );
endinterface

// File: rtl/npc_gen.sv
// Next-PC generator: decodes the D-stage instruction into a redirect
// select, computes candidate targets, and holds the fetch PC plus the
// delay-slot, fetch-address-error and redirect-count flags.
module npc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
   input logic       clk,
   input logic       reset,
   npc_gen_if.slave  bus
);

   typedef enum logic [2:0] {
      SEL_PC4   = 3'b000,
      SEL_BR    = 3'b001,
      SEL_JR    = 3'b010,
      SEL_J_JAL = 3'b011,
      SEL_JI    = 3'b100
   } npc_sel_e;

   localparam logic [31:0] ERET_INSTR = 32'h4200_0018;
   localparam logic [31:0] PC_HI      = EXC_PC + 32'h0000_1C7C;

   logic [5:0]  op;
   logic [4:0]  rt_field;
   logic [5:0]  funct;
   logic        is_eret;
   logic        is_jb;
   npc_sel_e    sel_raw;
   npc_sel_e    sel;

   logic [31:0] PC_F_q, PC_F_d;
   logic        bd_D_q, bd_D_d;
   logic        adel_F_q, adel_F_d;
   logic [15:0] redir_cnt_q, redir_cnt_d;

   assign op       = bus.instr_D[31:26];
   assign rt_field = bus.instr_D[20:16];
   assign funct    = bus.instr_D[5:0];
   assign is_eret  = (bus.instr_D == ERET_INSTR);

   // Candidate redirect targets
   assign bus.BR    = bus.PC4_D + {{14{bus.instr_D[15]}}, bus.instr_D[15:0], 2'b00};
   assign bus.J_JAL = {bus.PC4_D[31:28], bus.instr_D[25:0], 2'b00};
   assign bus.JR    = bus.rs_D;
   assign bus.JI    = bus.epc;

   // Classify instr_D: branch/jump membership and unstalled redirect select
   always_comb begin
      sel_raw = SEL_PC4;
      is_jb   = 1'b0;
      case (op)
         6'h04: begin
            is_jb = 1'b1;
            if (bus.rs_D == bus.rt_D) sel_raw = SEL_BR;
         end
         6'h05: begin
            is_jb = 1'b1;
            if (bus.rs_D != bus.rt_D) sel_raw = SEL_BR;
         end
         6'h06: begin
            is_jb = 1'b1;
            if ($signed(bus.rs_D) <= 0) sel_raw = SEL_BR;
         end
         6'h07: begin
            is_jb = 1'b1;
            if ($signed(bus.rs_D) > 0) sel_raw = SEL_BR;
         end
         6'h01: begin
            if (rt_field == 5'd0) begin
               is_jb = 1'b1;
               if (bus.rs_D[31]) sel_raw = SEL_BR;
            end else if (rt_field == 5'd1) begin
               is_jb = 1'b1;
               if (!bus.rs_D[31]) sel_raw = SEL_BR;
            end
         end
         6'h02, 6'h03: begin
            is_jb   = 1'b1;
            sel_raw = SEL_J_JAL;
         end
         6'h00: begin
            if (funct == 6'h08 || funct == 6'h09) begin
               is_jb   = 1'b1;
               sel_raw = SEL_JR;
            end
         end
         default: ;
      endcase
      if (is_eret) sel_raw = SEL_JI;
   end

   // A stall suppresses any redirect so it fires once, after the stall drops
   always_comb begin
      sel = bus.stall ? SEL_PC4 : sel_raw;
   end

   assign bus.NPC_ctrl = sel;
   assign bus.flush_FD = is_eret && !bus.stall;

   // Next state for fetch PC and status flags; everything holds on stall
   always_comb begin
      PC_F_d      = PC_F_q;
      bd_D_d      = bd_D_q;
      adel_F_d    = adel_F_q;
      redir_cnt_d = redir_cnt_q;
      if (!bus.stall) begin
         PC_F_d   = bus.NPC;
         bd_D_d   = is_jb;
         adel_F_d = (bus.NPC[1:0] != 2'b00) || (bus.NPC < RESET_PC) || (bus.NPC > PC_HI);
         if (sel != SEL_PC4 && redir_cnt_q != 16'hFFFF)
            redir_cnt_d = redir_cnt_q + 16'd1;
      end
   end

   // State registers; reset takes priority over stall
   always_ff @(posedge clk) begin
      if (!reset) begin
         PC_F_q      <= RESET_PC;
         bd_D_q      <= 1'b0;
         adel_F_q    <= 1'b0;
         redir_cnt_q <= '0;
      end else begin
         PC_F_q      <= PC_F_d;
         bd_D_q      <= bd_D_d;
         adel_F_q    <= adel_F_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign bus.PC_F      = PC_F_q;
   assign bus.PC4_F     = PC_F_q + 32'd4;
   assign bus.bd_D      = bd_D_q;
   assign bus.adel_F    = adel_F_q;
   assign bus.redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_npc_gen.sv
// Bench for npc_gen: directed scenarios followed by randomized instruction
// streams checked against a transaction-level model of the fetch PC.
module tb_npc_gen;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC   = 32'h0000_4180;
   localparam logic [31:0] ERET     = 32'h4200_0018;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;

   npc_gen_if bus ();

   npc_gen #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // model state
   logic [31:0] m_pc;
   bit          m_bd, m_adel;
   int          m_cnt;

   // inputs of the cycle in flight
   logic        c_rst, c_st;
   logic [31:0] c_npc;
   int          c_ctrl;
   bit          c_jb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit out_of_range(input logic [31:0] a);
      return (a % 4 != 0) || (a < RESET_PC) || (a > EXC_PC + 32'h1C7C);
   endfunction

   // Drive one cycle's inputs and check combinational outputs.
   task automatic apply(input logic rst_n, input logic st, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ep, input logic [31:0] npc,
                        input int ectrl, input bit jb, input bit dc);
      int off;
      reset       = rst_n;
      bus.stall   = st;
      bus.instr_D = ins;
      bus.PC4_D   = pc4;
      bus.rs_D    = rs;
      bus.rt_D    = rt;
      bus.epc     = ep;
      bus.NPC     = npc;
      c_rst  = rst_n;
      c_st   = st;
      c_npc  = npc;
      c_ctrl = st ? 0 : ectrl;
      c_jb   = jb;
      #3;
      if (dc) begin
         off = $signed(ins[15:0]);
         chk("ctrl",  {29'd0, bus.NPC_ctrl}, c_ctrl);
         chk("flush", {31'd0, bus.flush_FD}, (ectrl == 4 && !st) ? 1 : 0);
         chk("BR",    bus.BR, pc4 + off * 4);
         chk("J",     bus.J_JAL, (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4));
         chk("JR",    bus.JR, rs);
         chk("JI",    bus.JI, ep);
      end
   endtask

   // Clock edge: advance the model, then check registered outputs.
   task automatic tick(input bit dc);
      @(posedge clk);
      if (!c_rst) begin
         m_pc = RESET_PC; m_bd = 0; m_adel = 0; m_cnt = 0;
      end else if (!c_st) begin
         m_pc   = c_npc;
         m_adel = out_of_range(c_npc);
         m_bd   = c_jb;
         if (c_ctrl != 0 && m_cnt < 65535) m_cnt++;
      end
      #1;
      if (dc) begin
         chk("PC_F",  bus.PC_F, m_pc);
         chk("PC4_F", bus.PC4_F, m_pc + 4);
         chk("bd_D",  {31'd0, bus.bd_D}, m_bd);
         chk("adel",  {31'd0, bus.adel_F}, m_adel);
         chk("cnt",   {16'd0, bus.redir_cnt}, m_cnt);
      end
   endtask

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ins, pc4, rs, rt, ep, npc, tgt, idx, beq_i, jal_i;
      logic [4:0]  rsn, rtn;
      logic [15:0] imm;
      int          k, ec, off;
      bit          jb, taken, st, rn;

      beq_i = {6'h04, 5'd1, 5'd2, 16'hFFFE};
      jal_i = 32'h0C00_0C00;
      m_pc = RESET_PC; m_bd = 0; m_adel = 0; m_cnt = 0;
      reset = 1'b0;
      bus.stall = 1'b0; bus.instr_D = '0; bus.PC4_D = '0;
      bus.rs_D = '0; bus.rt_D = '0; bus.epc = '0; bus.NPC = '0;
      @(posedge clk); #1;

      // reset state
      apply(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234, 0, 0, 1);
      tick(1);
      chk("rst_pc",  bus.PC_F, 32'h3000);
      chk("rst_pc4", bus.PC4_F, 32'h3004);
      chk("rst_cnt", {16'd0, bus.redir_cnt}, 32'd0);
      chk("rst_bd",  {31'd0, bus.bd_D}, 32'd0);

      // taken beq backwards
      apply(1'b1, 1'b0, beq_i, 32'h3008, 32'd5, 32'd5, 32'h0, 32'h3000, 1, 1, 1);
      chk("beq_br",   bus.BR, 32'h3000);
      chk("beq_ctrl", {29'd0, bus.NPC_ctrl}, 32'd1);
      tick(1);
      chk("beq_bd",  {31'd0, bus.bd_D}, 32'd1);
      chk("beq_cnt", {16'd0, bus.redir_cnt}, 32'd1);

      // same beq stalled three cycles, then released
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b1, beq_i, 32'h3008, 32'd5, 32'd5, 32'h0, 32'h3000, 1, 1, 1);
         chk("stall_ctrl", {29'd0, bus.NPC_ctrl}, 32'd0);
         tick(1);
         chk("stall_pc", bus.PC_F, 32'h3000);
      end
      apply(1'b1, 1'b0, beq_i, 32'h3008, 32'd5, 32'd5, 32'h0, 32'h3000, 1, 1, 1);
      chk("unstall_ctrl", {29'd0, bus.NPC_ctrl}, 32'd1);
      tick(1);
      chk("unstall_cnt", {16'd0, bus.redir_cnt}, 32'd2);

      // jr to a misaligned target
      apply(1'b1, 1'b0, 32'h0020_0008, 32'h3004, 32'h3002, 32'h0, 32'h0, 32'h3002, 2, 1, 1);
      chk("jr_ctrl", {29'd0, bus.NPC_ctrl}, 32'd2);
      tick(1);
      chk("jr_pc",   bus.PC_F, 32'h3002);
      chk("jr_adel", {31'd0, bus.adel_F}, 32'd1);

      // eret
      apply(1'b1, 1'b0, ERET, 32'h3004, 32'h0, 32'h0, 32'h3100, 32'h3100, 4, 0, 1);
      chk("eret_ctrl",  {29'd0, bus.NPC_ctrl}, 32'd4);
      chk("eret_flush", {31'd0, bus.flush_FD}, 32'd1);
      tick(1);
      chk("eret_pc", bus.PC_F, 32'h3100);
      chk("eret_bd", {31'd0, bus.bd_D}, 32'd0);

      // address-range boundaries
      apply(1'b1, 1'b0, 32'h0, 32'h3104, 32'h0, 32'h0, 32'h0, 32'h5DFC, 0, 0, 1);
      tick(1);
      chk("hi_edge_adel", {31'd0, bus.adel_F}, 32'd0);
      apply(1'b1, 1'b0, 32'h0, 32'h3104, 32'h0, 32'h0, 32'h0, 32'h5E00, 0, 0, 1);
      tick(1);
      chk("hi_out_adel", {31'd0, bus.adel_F}, 32'd1);
      apply(1'b1, 1'b0, 32'h0, 32'h3104, 32'h0, 32'h0, 32'h0, 32'h2FFC, 0, 0, 1);
      tick(1);
      chk("lo_out_adel", {31'd0, bus.adel_F}, 32'd1);

      // reset while a jal is redirecting, also asserted with stall
      apply(1'b0, 1'b1, jal_i, 32'h3008, 32'h0, 32'h0, 32'h0, 32'h3000, 3, 1, 1);
      tick(1);
      chk("rst_mid_pc",  bus.PC_F, RESET_PC);
      chk("rst_mid_cnt", {16'd0, bus.redir_cnt}, 32'd0);

      // counter saturation
      for (int i = 0; i < 65535; i++) begin
         apply(1'b1, 1'b0, jal_i, 32'h3008, 32'h0, 32'h0, 32'h0, 32'h3000, 3, 1, 0);
         tick(0);
      end
      chk("sat_pre", {16'd0, bus.redir_cnt}, 32'h0000_FFFF);
      apply(1'b1, 1'b0, jal_i, 32'h3008, 32'h0, 32'h0, 32'h0, 32'h3000, 3, 1, 1);
      tick(1);
      chk("sat_hold", {16'd0, bus.redir_cnt}, 32'h0000_FFFF);

      // randomized instruction stream
      apply(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1);
      tick(1);
      for (int n = 0; n < 3000; n++) begin
         k   = $urandom_range(0, 13);
         rsn = 5'($urandom);
         rtn = 5'($urandom);
         imm = 16'($urandom);
         idx = $urandom & 32'h03FF_FFFF;
         rs  = pick_op();
         rt  = $urandom_range(0, 1) ? rs : pick_op();
         pc4 = $urandom & 32'hFFFF_FFFC;
         ep  = $urandom;
         ec  = 0;
         jb  = 1;
         taken = 0;
         case (k)
            0:  begin ins = {6'h04, rsn, rtn, imm};  taken = (rs == rt); end
            1:  begin ins = {6'h05, rsn, rtn, imm};  taken = (rs != rt); end
            2:  begin ins = {6'h06, rsn, 5'd0, imm}; taken = ($signed(rs) <= 0); end
            3:  begin ins = {6'h07, rsn, 5'd0, imm}; taken = ($signed(rs) > 0); end
            4:  begin ins = {6'h01, rsn, 5'd0, imm}; taken = ($signed(rs) < 0); end
            5:  begin ins = {6'h01, rsn, 5'd1, imm}; taken = ($signed(rs) >= 0); end
            6:  begin ins = (32'h02 << 26) | idx; ec = 3; end
            7:  begin ins = (32'h03 << 26) | idx; ec = 3; end
            8:  begin ins = {6'h00, rsn, 15'd0, 6'h08}; ec = 2; end
            9:  begin ins = {6'h00, rsn, 5'd0, 5'd31, 5'd0, 6'h09}; ec = 2; end
            10: begin ins = ERET; ec = 4; jb = 0; end
            11: begin ins = {6'h23, rsn, rtn, imm}; jb = 0; end
            12: begin ins = {6'h00, rsn, rtn, 5'd3, 5'd0, 6'h21}; jb = 0; end
            default: begin ins = {6'h01, rsn, 5'd2, imm}; jb = 0; end
         endcase
         if (taken) ec = 1;
         off = $signed(imm);
         case (ec)
            1:       tgt = pc4 + off * 4;
            2:       tgt = rs;
            3:       tgt = (pc4 & 32'hF000_0000) | (idx * 4);
            4:       tgt = ep;
            default: tgt = m_pc + 4;
         endcase
         case ($urandom_range(0, 6))
            0, 1, 2, 3: npc = tgt;
            4:          npc = RESET_PC + 4 * $urandom_range(0, 32'h0B7F);
            5:          npc = $urandom;
            default: begin
               case ($urandom_range(0, 3))
                  0:       npc = RESET_PC;
                  1:       npc = RESET_PC - 4;
                  2:       npc = EXC_PC + 32'h1C7C;
                  default: npc = EXC_PC + 32'h1C80;
               endcase
            end
         endcase
         st = ($urandom_range(0, 3) == 0);
         rn = ($urandom_range(0, 19) != 0);
         apply(rn, st, ins, pc4, rs, rt, ep, npc, ec, jb, 1);
         tick(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
